// File: rtl/sm_clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sm_clk_ctrl_pkg
// Shared definitions for the schoolMIPS run/halt/single-step clock controller.
//   state_t  : controller FSM encoding (HALT=0, RUN=1, STEP=2, WAIT_REL=3)
//   STATE_W  : width of the encoded state as seen on the state output
// -----------------------------------------------------------------------------
package sm_clk_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    STEP     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

endpackage

// File: rtl/sm_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// sm_clk_ctrl_if
// Control/status bundle between the board-side inputs, the core and the
// clock controller.
//   devide    : pulse period select, one tick every 2^devide clock cycles
//   run       : free-run request level
//   step      : step button level (synchronized, still bouncy)
//   haltReq   : halt request from the core
//   clkEn     : one-cycle advance pulse to the core
//   state     : controller FSM state
//   stepDone  : one-cycle pulse when a single step completes
//   cycleCnt  : number of clkEn pulses issued
// Optional (SM_CLK_CTRL_BREAK_EN): pc, breakAddr, breakEn breakpoint inputs.
// Modports: master = controller side, slave = board/core side.
// -----------------------------------------------------------------------------
interface sm_clk_ctrl_if
  import sm_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int CNT_W = 32
) ();

  logic [DIV_W-1:0]   devide;
  logic               run;
  logic               step;
  logic               haltReq;
  logic               clkEn;
  logic [STATE_W-1:0] state;
  logic               stepDone;
  logic [CNT_W-1:0]   cycleCnt;
`ifdef SM_CLK_CTRL_BREAK_EN
  logic [31:0]        pc;
  logic [31:0]        breakAddr;
  logic               breakEn;
`endif

  modport master (
    input  devide, run, step, haltReq,
`ifdef SM_CLK_CTRL_BREAK_EN
    input  pc, breakAddr, breakEn,
`endif
    output clkEn, state, stepDone, cycleCnt
  );

  modport slave (
    output devide, run, step, haltReq,
`ifdef SM_CLK_CTRL_BREAK_EN
    output pc, breakAddr, breakEn,
`endif
    input  clkEn, state, stepDone, cycleCnt
  );

endinterface

// File: rtl/sm_debouncer.sv
// -----------------------------------------------------------------------------
// sm_debouncer
// Step-button debouncer. The debounced level follows the raw input only after
// the raw input has disagreed with it for DEB_LEN consecutive cycles.
//   clk      : clock
//   rst_n    : asynchronous reset, active low
//   step     : raw (synchronized) button level
//   stepDb   : debounced level
//   stepRise : one-cycle pulse, high in the first cycle stepDb is 1
// -----------------------------------------------------------------------------
module sm_debouncer #(
  parameter int DEB_LEN = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic stepDb,
  output logic stepRise
);

  localparam int            CW   = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_LEN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] diff_cnt;

  // Any agreeing cycle restarts the stability window; the level flips on the
  // DEB_LEN-th consecutive disagreeing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_cnt <= '0;
      stepDb   <= 1'b0;
      stepRise <= 1'b0;
    end else begin
      stepRise <= 1'b0;
      if (step == stepDb) begin
        diff_cnt <= '0;
      end else if (diff_cnt == LAST) begin
        diff_cnt <= '0;
        stepDb   <= step;
        stepRise <= step;
      end else begin
        diff_cnt <= diff_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/sm_clk_ctrl.sv
// -----------------------------------------------------------------------------
// sm_clk_ctrl
// Run/halt/single-step controller for the schoolMIPS core clock. Produces a
// stream of one-cycle clock-enable pulses in the clkIn domain instead of a
// divided clock.
//   clkIn  : system clock
//   rst_n  : asynchronous reset, active low
//   bus    : sm_clk_ctrl_if.master (devide/run/step/haltReq in,
//            clkEn/state/stepDone/cycleCnt out)
// Optional feature macro SM_CLK_CTRL_BREAK_EN: adds pc/breakAddr/breakEn;
// a breakpoint hit in RUN behaves like haltReq, breakpoints are ignored in STEP.
// -----------------------------------------------------------------------------
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int DEB_LEN = 1000,
  parameter int DIV_W   = 4,
  parameter int CNT_W   = 32
) (
  input  logic          clkIn,
  input  logic          rst_n,
  sm_clk_ctrl_if.master bus
);

  // Prescaler must reach 2^(2^DIV_W - 1) - 1 for the largest devide value.
  localparam int               PRE_W   = (1 << DIV_W) - 1;
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             stepDb;
  logic             stepRise;
  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_limit;
  logic             tick;
  logic             pre_clear;
  logic             brk_hit;
  logic             run_stop;

  state_t           state_q;
  logic             clk_en_q;
  logic             step_done_q;
  logic [CNT_W-1:0] cycle_cnt;

  sm_debouncer #(
    .DEB_LEN (DEB_LEN)
  ) u_debouncer (
    .clk      (clkIn),
    .rst_n    (rst_n),
    .step     (bus.step),
    .stepDb   (stepDb),
    .stepRise (stepRise)
  );

  // For devide == 2^DIV_W - 1 the shift overflows to zero, and zero minus one
  // is the all-ones limit we want.
  assign pre_limit = (PRE_ONE << bus.devide) - PRE_ONE;
  assign tick      = (pre_cnt == pre_limit);

  // Leaving HALT restarts the period so the first pulse is a full period away.
  assign pre_clear = (state_q == HALT) && (bus.run || stepRise);

`ifdef SM_CLK_CTRL_BREAK_EN
  assign brk_hit = bus.breakEn && (bus.pc == bus.breakAddr);
`else
  assign brk_hit = 1'b0;
`endif

  assign run_stop = bus.haltReq || !bus.run || brk_hit;

  // A count above a freshly lowered limit wraps without producing a tick.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (pre_clear || (pre_cnt >= pre_limit)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  // Pulses are registered: decided on a tick, visible the following cycle.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HALT;
      clk_en_q    <= 1'b0;
      step_done_q <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      clk_en_q    <= 1'b0;
      step_done_q <= 1'b0;
      case (state_q)
        HALT: begin
          if (bus.run) begin
            state_q <= RUN;
          end else if (stepRise) begin
            state_q <= STEP;
          end
        end
        RUN: begin
          if (run_stop) begin
            state_q <= HALT;
          end else if (tick) begin
            clk_en_q  <= 1'b1;
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
        end
        STEP: begin
          // haltReq and breakpoints are deliberately not looked at here.
          if (tick) begin
            clk_en_q    <= 1'b1;
            step_done_q <= 1'b1;
            cycle_cnt   <= cycle_cnt + CNT_ONE;
            state_q     <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!stepDb) begin
            state_q <= HALT;
          end
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign bus.clkEn    = clk_en_q;
  assign bus.stepDone = step_done_q;
  assign bus.state    = state_q;
  assign bus.cycleCnt = cycle_cnt;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm_clk_ctrl
// Directed self-checking bench for sm_clk_ctrl (DEB_LEN = 8, DIV_W = 4,
// CNT_W = 32). Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point, i.e. after the preceding edge has settled.
// Breakpoint scenario is included when SM_CLK_CTRL_BREAK_EN is defined.
// -----------------------------------------------------------------------------
module tb_sm_clk_ctrl;

  logic clkIn;
  logic rst_n;
  int   total;
  int   bad;

  sm_clk_ctrl_if #(.DIV_W(4), .CNT_W(32)) bus ();

  sm_clk_ctrl #(
    .DEB_LEN (8),
    .DIV_W   (4),
    .CNT_W   (32)
  ) dut (
    .clkIn (clkIn),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic applyStimulus(input logic runV, input logic stepV,
                               input logic haltV, input logic [3:0] divV);
    bus.run     = runV;
    bus.step    = stepV;
    bus.haltReq = haltV;
    bus.devide  = divV;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2);
`ifdef SM_CLK_CTRL_BREAK_EN
    bus.pc        = 32'h0;
    bus.breakAddr = 32'h0000_0010;
    bus.breakEn   = 1'b0;
`endif

    // Reset values
    cyc(2);
    checkOutput("rst_state", 64'(bus.state), 64'd0);
    checkOutput("rst_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("rst_stepDone", 64'(bus.stepDone), 64'd0);
    checkOutput("rst_cycleCnt", 64'(bus.cycleCnt), 64'd0);

    // Free run at devide=2: pulse every 4 cycles, first one 4 after entry
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
    cyc(1);
    checkOutput("run_entry_state", 64'(bus.state), 64'd1);
    checkOutput("run_entry_clkEn", 64'(bus.clkEn), 64'd0);
    cyc(3);
    checkOutput("run_pre_first_clkEn", 64'(bus.clkEn), 64'd0);
    cyc(1);
    checkOutput("run_first_clkEn", 64'(bus.clkEn), 64'd1);
    checkOutput("run_first_cnt", 64'(bus.cycleCnt), 64'd1);
    for (int i = 2; i <= 10; i++) begin
      cyc(1);
      checkOutput("run_gap_clkEn", 64'(bus.clkEn), 64'd0);
      cyc(2);
      checkOutput("run_pre_clkEn", 64'(bus.clkEn), 64'd0);
      cyc(1);
      checkOutput("run_clkEn", 64'(bus.clkEn), 64'd1);
    end
    checkOutput("run_cnt10", 64'(bus.cycleCnt), 64'd10);

    // devide=0 gives a pulse every cycle; one-cycle haltReq stops with no pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(2);
    checkOutput("div0_clkEn", 64'(bus.clkEn), 64'd1);
    checkOutput("div0_cnt", 64'(bus.cycleCnt), 64'd12);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
    cyc(1);
    checkOutput("halt_state", 64'(bus.state), 64'd0);
    checkOutput("halt_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("halt_cnt", 64'(bus.cycleCnt), 64'd12);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(2);
    checkOutput("halt_hold_state", 64'(bus.state), 64'd0);
    checkOutput("halt_hold_cnt", 64'(bus.cycleCnt), 64'd12);

    // Bouncy step press then held: exactly one step
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2); cyc(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2); cyc(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2); cyc(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2); cyc(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2);
    cyc(7);
    checkOutput("deb_not_yet_state", 64'(bus.state), 64'd0);
    cyc(1);
    checkOutput("deb_rise_state", 64'(bus.state), 64'd0);
    cyc(1);
    checkOutput("step_entry_state", 64'(bus.state), 64'd2);
    cyc(3);
    checkOutput("step_pre_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("step_pre_state", 64'(bus.state), 64'd2);
    cyc(1);
    checkOutput("step_clkEn", 64'(bus.clkEn), 64'd1);
    checkOutput("step_done", 64'(bus.stepDone), 64'd1);
    checkOutput("step_wait_state", 64'(bus.state), 64'd3);
    checkOutput("step_cnt", 64'(bus.cycleCnt), 64'd13);
    cyc(1);
    checkOutput("step_clkEn_width", 64'(bus.clkEn), 64'd0);
    checkOutput("step_done_width", 64'(bus.stepDone), 64'd0);
    cyc(10);
    checkOutput("held_state", 64'(bus.state), 64'd3);
    checkOutput("held_cnt", 64'(bus.cycleCnt), 64'd13);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2);
    cyc(8);
    checkOutput("release_wait_state", 64'(bus.state), 64'd3);
    cyc(1);
    checkOutput("release_halt_state", 64'(bus.state), 64'd0);

    // run and stepRise together: run wins, no single-step pulse
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2);
    cyc(8);
    checkOutput("prio_pre_state", 64'(bus.state), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2);
    cyc(1);
    checkOutput("prio_state", 64'(bus.state), 64'd1);
    cyc(3);
    checkOutput("prio_pre_clkEn", 64'(bus.clkEn), 64'd0);
    cyc(1);
    checkOutput("prio_clkEn", 64'(bus.clkEn), 64'd1);
    checkOutput("prio_stepDone", 64'(bus.stepDone), 64'd0);
    checkOutput("prio_run_state", 64'(bus.state), 64'd1);
    checkOutput("prio_cnt", 64'(bus.cycleCnt), 64'd14);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2);
    cyc(1);
    checkOutput("prio_stop_state", 64'(bus.state), 64'd0);
    cyc(10);

    // cycleCnt wraps from all-ones to zero
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    checkOutput("wrap_preload", 64'(bus.cycleCnt), 64'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1);
    checkOutput("wrap_entry_clkEn", 64'(bus.clkEn), 64'd0);
    cyc(1);
    checkOutput("wrap_clkEn", 64'(bus.clkEn), 64'd1);
    checkOutput("wrap_cnt", 64'(bus.cycleCnt), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1);
    checkOutput("wrap_stop_state", 64'(bus.state), 64'd0);
    checkOutput("wrap_stop_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("wrap_stop_cnt", 64'(bus.cycleCnt), 64'd0);

    // Asynchronous reset in the middle of a step, before its tick
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2);
    cyc(9);
    checkOutput("mid_step_state", 64'(bus.state), 64'd2);
    cyc(2);
    checkOutput("mid_step_clkEn", 64'(bus.clkEn), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", 64'(bus.state), 64'd0);
    checkOutput("async_rst_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("async_rst_stepDone", 64'(bus.stepDone), 64'd0);
    checkOutput("async_rst_cnt", 64'(bus.cycleCnt), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd2);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    checkOutput("post_rst_state", 64'(bus.state), 64'd0);
    checkOutput("post_rst_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("post_rst_cnt", 64'(bus.cycleCnt), 64'd0);

`ifdef SM_CLK_CTRL_BREAK_EN
    // Breakpoint hit in RUN halts with no pulse in that cycle
    bus.pc      = 32'h0;
    bus.breakEn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1);
    checkOutput("brk_entry_state", 64'(bus.state), 64'd1);
    cyc(2);
    checkOutput("brk_pre_clkEn", 64'(bus.clkEn), 64'd1);
    checkOutput("brk_pre_cnt", 64'(bus.cycleCnt), 64'd2);
    bus.pc = 32'h0000_0010;
    cyc(1);
    checkOutput("brk_state", 64'(bus.state), 64'd0);
    checkOutput("brk_clkEn", 64'(bus.clkEn), 64'd0);
    checkOutput("brk_cnt", 64'(bus.cycleCnt), 64'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
